// File: rtl/io_port_responder_if.sv
// Bus bundle between the memory stage / external devices and the IN/OUT port responder.
interface io_port_responder_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    // Processor side
    logic                  ior;
    logic                  iow;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  stall;
    // External input device
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    // External output device
    logic [DATA_WIDTH-1:0] out_port;
    logic                  out_valid;
    logic                  out_ack;

    modport slave (
        input  ior, iow, wdata, in_data, in_valid, out_ack,
        output rdata, rdata_valid, stall, in_ready, out_port, out_valid
    );

    modport master (
        output ior, iow, wdata, in_data, in_valid, out_ack,
        input  rdata, rdata_valid, stall, in_ready, out_port, out_valid
    );
endinterface

// File: rtl/io_port_responder.sv
// Responder for processor IN/OUT instructions: input FIFO fed by an external device,
// latched output port toward an external device, combinational stall to the pipeline.
module io_port_responder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PTR_W      = 2
) (
    input logic                 clk,
    input logic                 reset,
    io_port_responder_if.slave  bus
);
    typedef enum logic [0:0] {InIdle, InWait}   in_state_e;
    typedef enum logic [0:0] {OutIdle, OutBusy} out_state_e;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  fifo_full, fifo_empty, in_ready, push, pop;

    in_state_e             in_state_q, in_state_d;
    out_state_e            out_state_q, out_state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, out_port_q, out_port_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  stall_in, stall_out;

    assign fifo_full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Derived from the registered count only, so a pop at full never frees a slot early.
    assign in_ready   = reset & ~fifo_full;
    assign push       = bus.in_valid & in_ready;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // IN request FSM: pop the head when available, otherwise stall until a word arrives
    always_comb begin
        in_state_d    = in_state_q;
        pop           = 1'b0;
        stall_in      = 1'b0;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        unique case (in_state_q)
            InIdle: begin
                if (bus.ior) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        in_state_d = InWait;
                        stall_in   = 1'b1;
                    end
                end
            end
            InWait: begin
                if (!bus.ior) begin
                    in_state_d = InIdle;  // flushed request
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    in_state_d = InIdle;
                end else begin
                    stall_in = 1'b1;
                end
            end
            default: in_state_d = InIdle;
        endcase
        if (pop) begin
            rdata_d       = mem_q[rd_ptr_q];
            rdata_valid_d = 1'b1;
        end
    end

    // OUT request FSM: latch wdata unless a previous value is still unacknowledged
    always_comb begin
        out_state_d = out_state_q;
        out_port_d  = out_port_q;
        stall_out   = 1'b0;
        unique case (out_state_q)
            OutIdle: begin
                if (bus.iow) begin
                    out_port_d  = bus.wdata;
                    out_state_d = OutBusy;
                end
            end
            OutBusy: begin
                if (bus.out_ack) begin
                    if (bus.iow) out_port_d = bus.wdata;
                    else         out_state_d = OutIdle;
                end else if (bus.iow) begin
                    stall_out = 1'b1;
                end
            end
            default: out_state_d = OutIdle;
        endcase
    end

    // Control and output state, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_state_q    <= InIdle;
            out_state_q   <= OutIdle;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            out_port_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            in_state_q    <= in_state_d;
            out_state_q   <= out_state_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            out_port_q    <= out_port_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_data;
    end

    assign bus.in_ready    = in_ready;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.out_port    = out_port_q;
    assign bus.out_valid   = (out_state_q == OutBusy);
    assign bus.stall       = reset & (stall_in | stall_out);
endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: directed cycle table, async-reset sequence, random vs queue model.
module tb_io_port_responder;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    io_port_responder_if #(.DATA_WIDTH(16)) bus ();

    io_port_responder #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(4),
        .PTR_W     (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ior, iow;
        logic [15:0] wdata;
        logic        iv;
        logic [15:0] id;
        logic        ack;
        logic        s, ir, rv;
        logic [15:0] rd;
        logic        ov;
        logic [15:0] op;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ior, logic iow, logic [15:0] wdata, logic iv,
                                logic [15:0] id, logic ack, logic s, logic ir, logic rv,
                                logic [15:0] rd, logic ov, logic [15:0] op);
        vec_t v;
        v.ior = ior; v.iow = iow; v.wdata = wdata; v.iv = iv; v.id = id; v.ack = ack;
        v.s = s; v.ir = ir; v.rv = rv; v.rd = rd; v.ov = ov; v.op = op;
        return v;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic ior, logic iow, logic [15:0] wdata, logic iv,
                         logic [15:0] id, logic ack);
        bus.ior = ior; bus.iow = iow; bus.wdata = wdata;
        bus.in_valid = iv; bus.in_data = id; bus.out_ack = ack;
    endtask

    task automatic chk_all(string tag, logic s, logic ir, logic rv, logic [15:0] rd,
                           logic ov, logic [15:0] op);
        chk({tag, " stall"},       16'(bus.stall),       16'(s));
        chk({tag, " in_ready"},    16'(bus.in_ready),    16'(ir));
        chk({tag, " rdata_valid"}, 16'(bus.rdata_valid), 16'(rv));
        chk({tag, " rdata"},       bus.rdata,            rd);
        chk({tag, " out_valid"},   16'(bus.out_valid),   16'(ov));
        chk({tag, " out_port"},    bus.out_port,         op);
    endtask

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] m_rd, m_op;
    logic        m_rv, m_ov;

    initial begin
        // ior, iow, wdata, iv, id, ack  |  stall, in_ready, rv, rdata, ov, out_port
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   0, 0,1,0,16'h0,   0,16'h0));    // 0
        tbl.push_back(mk(0,0,16'h0,   1,16'h1111,0, 0,1,0,16'h0,   0,16'h0));
        tbl.push_back(mk(0,0,16'h0,   1,16'h2222,0, 0,1,0,16'h0,   0,16'h0));
        tbl.push_back(mk(1,0,16'h0,   0,16'h0,   0, 0,1,0,16'h0,   0,16'h0));
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   0, 0,1,1,16'h1111,0,16'h0));
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   0, 0,1,0,16'h1111,0,16'h0));    // 5
        tbl.push_back(mk(1,0,16'h0,   0,16'h0,   0, 0,1,0,16'h1111,0,16'h0));
        tbl.push_back(mk(1,0,16'h0,   0,16'h0,   0, 1,1,1,16'h2222,0,16'h0));
        tbl.push_back(mk(1,0,16'h0,   0,16'h0,   0, 1,1,0,16'h2222,0,16'h0));
        tbl.push_back(mk(1,0,16'h0,   1,16'hBEEF,0, 1,1,0,16'h2222,0,16'h0));
        tbl.push_back(mk(1,0,16'h0,   0,16'h0,   0, 0,1,0,16'h2222,0,16'h0));    // 10
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   0, 0,1,1,16'hBEEF,0,16'h0));
        tbl.push_back(mk(0,1,16'h00A5,0,16'h0,   0, 0,1,0,16'hBEEF,0,16'h0));
        tbl.push_back(mk(0,1,16'h005A,0,16'h0,   0, 1,1,0,16'hBEEF,1,16'h00A5));
        tbl.push_back(mk(0,1,16'h005A,0,16'h0,   0, 1,1,0,16'hBEEF,1,16'h00A5));
        tbl.push_back(mk(0,1,16'h005A,0,16'h0,   1, 0,1,0,16'hBEEF,1,16'h00A5)); // 15
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   0, 0,1,0,16'hBEEF,1,16'h005A));
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   1, 0,1,0,16'hBEEF,1,16'h005A));
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   0, 0,1,0,16'hBEEF,0,16'h005A));
        tbl.push_back(mk(1,1,16'h1234,0,16'h0,   0, 1,1,0,16'hBEEF,0,16'h005A));
        tbl.push_back(mk(1,0,16'h0,   1,16'h7777,0, 1,1,0,16'hBEEF,1,16'h1234)); // 20
        tbl.push_back(mk(1,0,16'h0,   0,16'h0,   0, 0,1,0,16'hBEEF,1,16'h1234));
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   1, 0,1,1,16'h7777,1,16'h1234));
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   0, 0,1,0,16'h7777,0,16'h1234));
        tbl.push_back(mk(0,0,16'h0,   1,16'h00A0,0, 0,1,0,16'h7777,0,16'h1234));
        tbl.push_back(mk(0,0,16'h0,   1,16'h00A1,0, 0,1,0,16'h7777,0,16'h1234)); // 25
        tbl.push_back(mk(0,0,16'h0,   1,16'h00A2,0, 0,1,0,16'h7777,0,16'h1234));
        tbl.push_back(mk(0,0,16'h0,   1,16'h00A3,0, 0,1,0,16'h7777,0,16'h1234));
        tbl.push_back(mk(0,0,16'h0,   1,16'h00A4,0, 0,0,0,16'h7777,0,16'h1234));
        tbl.push_back(mk(1,0,16'h0,   1,16'h00A4,0, 0,0,0,16'h7777,0,16'h1234));
        tbl.push_back(mk(0,0,16'h0,   1,16'h00A4,0, 0,1,1,16'h00A0,0,16'h1234)); // 30
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   0, 0,0,0,16'h00A0,0,16'h1234));
        tbl.push_back(mk(1,0,16'h0,   0,16'h0,   0, 0,0,0,16'h00A0,0,16'h1234));
        tbl.push_back(mk(1,0,16'h0,   0,16'h0,   0, 0,1,1,16'h00A1,0,16'h1234));
        tbl.push_back(mk(1,0,16'h0,   0,16'h0,   0, 0,1,1,16'h00A2,0,16'h1234));
        tbl.push_back(mk(1,0,16'h0,   0,16'h0,   0, 0,1,1,16'h00A3,0,16'h1234)); // 35
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   0, 0,1,1,16'h00A4,0,16'h1234));
        tbl.push_back(mk(0,0,16'h0,   0,16'h0,   0, 0,1,0,16'h00A4,0,16'h1234));

        // Power-on reset
        reset = 1'b0;
        drive(0, 0, 16'h0, 0, 16'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 16'h0, 0, 16'h0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed cycle table
        foreach (tbl[i]) begin
            drive(tbl[i].ior, tbl[i].iow, tbl[i].wdata, tbl[i].iv, tbl[i].id, tbl[i].ack);
            @(negedge clk);
            chk_all($sformatf("row%0d", i), tbl[i].s, tbl[i].ir, tbl[i].rv, tbl[i].rd,
                    tbl[i].ov, tbl[i].op);
            @(posedge clk);
            #1;
        end

        // Async reset while IN is waiting and OUT holds an unacknowledged value
        drive(0, 1, 16'h0F0F, 0, 16'h0, 0);
        @(posedge clk); #1;
        drive(1, 0, 16'h0, 0, 16'h0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre-reset stall", 16'(bus.stall), 16'h1);
        chk("pre-reset out_port", bus.out_port, 16'h0F0F);
        #1 reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hDEAD;
        #1;
        chk_all("async reset", 0, 0, 0, 16'h0, 0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("held reset", 0, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 16'h0, 0);
        #2 reset = 1'b1;
        @(negedge clk);
        chk_all("post-reset", 0, 1, 0, 16'h0, 0, 16'h0);
        @(posedge clk); #1;
        bus.ior = 1'b1;
        @(negedge clk);
        chk_all("post-reset empty", 1, 1, 0, 16'h0, 0, 16'h0);
        @(posedge clk); #1;
        bus.ior = 1'b0;
        @(negedge clk);
        chk_all("post-reset no pulse", 0, 1, 0, 16'h0, 0, 16'h0);
        @(posedge clk); #1;

        // Random traffic against the queue model
        mq.delete();
        m_rd = '0; m_op = '0; m_rv = 1'b0; m_ov = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic r_ior, r_iow, r_iv, r_ack, e_s, do_push;
            logic [15:0] r_wd, r_id;
            r_ior = ($urandom_range(0, 99) < 35);
            r_iow = ($urandom_range(0, 99) < 35);
            r_iv  = ($urandom_range(0, 99) < 50);
            r_ack = ($urandom_range(0, 99) < 45);
            r_wd  = 16'($urandom);
            r_id  = 16'($urandom);
            drive(r_ior, r_iow, r_wd, r_iv, r_id, r_ack);
            @(negedge clk);
            e_s = (r_ior && mq.size() == 0) || (r_iow && m_ov && !r_ack);
            chk_all($sformatf("rand%0d", c), e_s, mq.size() < 4, m_rv, m_rd, m_ov, m_op);
            do_push = r_iv && (mq.size() < 4);
            if (r_ior && mq.size() > 0) begin
                m_rd = mq.pop_front();
                m_rv = 1'b1;
            end else begin
                m_rv = 1'b0;
            end
            if (do_push) mq.push_back(r_id);
            if (r_iow && (!m_ov || r_ack)) begin
                m_op = r_wd;
                m_ov = 1'b1;
            end else if (m_ov && r_ack) begin
                m_ov = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
